instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/loader_pkg.sv | 22 ++
 rtl/word_packer.sv | 43 ++++
 rtl/instruction_loader.sv | 137 +++++++++++++
 tb/tb_instruction_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the serial instruction loader: FSM states,
// default capacity/base address and the length of the count header.
package loader_pkg;

    // Load sequence: two header bytes, the data words, one checksum byte,
    // then one of two terminal states.
    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_e;

    localparam int unsigned          DEFAULT_MAX_WORDS = 256;
    localparam logic        [31:0]   DEFAULT_BASE_ADDR = 32'h0000_0000;

    // The word count N travels as this many bytes, high byte first.
    localparam int unsigned          HEADER_BYTES      = 2;

endpackage

// File: rtl/word_packer.sv
// Collects four bytes MSB first into a 32-bit word and flags the cycle in
// which the fourth byte is accepted. The completed word is presented
// combinationally so the caller can register it on that same edge.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // Assemble the word: the first three bytes wait in the shift register,
    // the fourth is spliced in live.
    assign word_o      = {shift_q, byte_i};
    assign word_done_o = byte_valid_i && (cnt_q == 2'd3);

    // Shift in each accepted byte; the 2-bit counter wraps after byte 4,
    // so the next byte starts a fresh word without any gap.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (byte_valid_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // Byte-position and partial-word registers; reset discards a partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Boot-time loader: receives a length-prefixed, checksummed byte stream,
// writes the instruction words into memory and releases the CPU only when
// the checksum matches.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int unsigned  MAX_WORDS = DEFAULT_MAX_WORDS,
    parameter logic [31:0]  BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned  CNT_W       = HEADER_BYTES * 8;
    localparam logic [31:0]  MAX_WORDS_W = 32'(MAX_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        word_idx_q, word_idx_d;
    logic [7:0]         csum_q, csum_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic               accept;
    logic               pack_valid;
    logic [31:0]        packed_word;
    logic               word_done;
    logic [CNT_W-1:0]   hdr_count;

    assign rx_ready   = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                        (state_q == DATA)   || (state_q == CHECK);
    assign accept     = rx_valid && rx_ready;
    assign pack_valid = accept && (state_q == DATA);
    assign hdr_count  = {count_q[CNT_W-1:8], rx_data};

    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);
    assign cpu_hold   = (state_q != DONE);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (pack_valid),
        .byte_i       (rx_data),
        .word_o       (packed_word),
        .word_done_o  (word_done)
    );

    // Next-state, checksum, address counter and write-strobe generation.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (which would infer a latch).
        state_d     = state_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            CNT_HI: begin
                if (accept) begin
                    count_d = {rx_data, 8'h00};
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    count_d = hdr_count;
                    if (hdr_count == '0) begin
                        state_d = CHECK;
                    end else if (32'(hdr_count) > MAX_WORDS_W) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    if (word_done) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        mem_wdata_d = packed_word;
                        word_idx_d  = word_idx_q + 16'd1;
                        if (word_idx_q == count_q - 16'd1) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? DONE : ERROR;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset wins over any byte or pending write.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= CNT_HI;
            count_q     <= '0;
            word_idx_q  <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: drives hand-built byte streams and
// checks write pulses, terminal flags and reset behaviour.
module tb_instruction_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          n_cmp;
    int          n_bad;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    instruction_loader dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one byte; it is accepted on the next rising edge. rx_valid stays
    // high so back-to-back calls form a continuous stream.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    function automatic logic [31:0] pattern_word(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return {kb, ~kb, kb ^ 8'h5A, 8'hC3};
    endfunction

    initial begin
        logic [7:0] xs;
        logic [31:0] w;
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // ---- reset state
        do_reset();
        check("rst_rx_ready",  32'(rx_ready),  32'd1);
        check("rst_cpu_hold",  32'(cpu_hold),  32'd1);
        check("rst_done",      32'(done),      32'd0);
        check("rst_error",     32'(error),     32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  mem_addr,       32'h0);
        check("rst_mem_wdata", mem_wdata,      32'h0);

        // ---- two words, correct checksum: 00^00^80^21^8E^12^00^00 = 3D
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h0000_8021);
        send_word(32'h8E12_0000);
        send_byte(8'h3D);
        idle();
        @(negedge clk);
        check("ok_nwrites",  32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check("ok_addr0", wr_addr_q[0], 32'h0);
            check("ok_data0", wr_data_q[0], 32'h0000_8021);
            check("ok_addr1", wr_addr_q[1], 32'h4);
            check("ok_data1", wr_data_q[1], 32'h8E12_0000);
        end
        check("ok_done",     32'(done),     32'd1);
        check("ok_error",    32'(error),    32'd0);
        check("ok_cpu_hold", 32'(cpu_hold), 32'd0);
        check("ok_rx_ready", 32'(rx_ready), 32'd0);
        check("ok_addr_hold",  mem_addr,  32'h4);
        check("ok_wdata_hold", mem_wdata, 32'h8E12_0000);
        // DONE is terminal: further bytes are ignored
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle();
        @(negedge clk);
        check("ok_term_done",    32'(done), 32'd1);
        check("ok_term_nwrites", 32'(wr_addr_q.size()), 32'd2);

        // ---- same stream, wrong checksum 3C
        do_reset();
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h0000_8021);
        send_word(32'h8E12_0000);
        send_byte(8'h3C);
        idle();
        @(negedge clk);
        check("bad3c_nwrites",  32'(wr_addr_q.size()), 32'd2);
        check("bad3c_error",    32'(error),    32'd1);
        check("bad3c_done",     32'(done),     32'd0);
        check("bad3c_cpu_hold", 32'(cpu_hold), 32'd1);

        // ---- same stream, checksum 00
        do_reset();
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h0000_8021);
        send_word(32'h8E12_0000);
        send_byte(8'h00);
        idle();
        @(negedge clk);
        check("bad00_nwrites",  32'(wr_addr_q.size()), 32'd2);
        check("bad00_error",    32'(error),    32'd1);
        check("bad00_done",     32'(done),     32'd0);
        check("bad00_cpu_hold", 32'(cpu_hold), 32'd1);
        check("bad00_rx_ready", 32'(rx_ready), 32'd0);

        // ---- oversize header 257: error right after second byte
        do_reset();
        send_byte(8'h01); send_byte(8'h01);
        idle();
        @(negedge clk);
        check("big_error",    32'(error),    32'd1);
        check("big_rx_ready", 32'(rx_ready), 32'd0);
        send_word(32'h1234_5678);
        send_word(32'h9ABC_DEF0);
        idle();
        @(negedge clk);
        check("big_nwrites", 32'(wr_addr_q.size()), 32'd0);
        check("big_error2",  32'(error), 32'd1);

        // ---- header exactly 256 is accepted (still loading)
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        idle();
        @(negedge clk);
        check("max_error",    32'(error),    32'd0);
        check("max_rx_ready", 32'(rx_ready), 32'd1);

        // ---- zero-length load, checksum 00 -> done
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle();
        @(negedge clk);
        check("zero_done",    32'(done), 32'd1);
        check("zero_nwrites", 32'(wr_addr_q.size()), 32'd0);

        // ---- zero-length load, checksum 01 -> error
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        idle();
        @(negedge clk);
        check("zero_bad_error", 32'(error), 32'd1);
        check("zero_bad_done",  32'(done),  32'd0);

        // ---- 256 words streamed with rx_valid held high throughout
        do_reset();
        xs = 8'h00;
        send_byte(8'h01); send_byte(8'h00);
        for (int k = 0; k < 256; k++) begin
            w  = pattern_word(k);
            xs = xs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            send_word(w);
        end
        send_byte(xs);
        idle();
        @(negedge clk);
        check("full_nwrites", 32'(wr_addr_q.size()), 32'd256);
        if (wr_addr_q.size() == 256) begin
            for (int k = 0; k < 256; k++) begin
                check($sformatf("full_addr%0d", k), wr_addr_q[k], 32'(k) * 32'd4);
                check($sformatf("full_data%0d", k), wr_data_q[k], pattern_word(k));
            end
        end
        check("full_done", 32'(done), 32'd1);

        // ---- reset arrives with the 4th byte of word 1 -> that write is dropped
        do_reset();
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h1122_3344);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h88;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        check("mid_nwrites",  32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check("mid_data0", wr_data_q[0], 32'h1122_3344);
        end
        check("mid_rx_ready", 32'(rx_ready), 32'd1);
        check("mid_mem_addr", mem_addr,      32'h0);
        check("mid_mem_we",   32'(mem_we),   32'd0);
        wr_addr_q.delete();
        wr_data_q.delete();
        // fresh stream: one word, checksum DE^AD^BE^EF = 22
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'hDEAD_BEEF);
        send_byte(8'h22);
        idle();
        @(negedge clk);
        check("fresh_nwrites", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check("fresh_addr0", wr_addr_q[0], 32'h0);
            check("fresh_data0", wr_data_q[0], 32'hDEAD_BEEF);
        end
        check("fresh_done", 32'(done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
